// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard/cache inputs and latch-control outputs of the pipeline controller
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stall;
  logic             flush_if;
  logic             flush_id;
  logic             flush_ex;
  logic             ihit;
  logic             dhit;
  logic             dmemREN_mem;
  logic             dmemWEN_mem;
  logic             halt_mem;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_clr;
  logic             idex_clr;
  logic             exmem_clr;
  logic             dmemREN;
  logic             dmemWEN;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Core side: drives hazard/cache status, consumes latch controls
  modport master (
    output stall, flush_if, flush_id, flush_ex, ihit, dhit,
           dmemREN_mem, dmemWEN_mem, halt_mem,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, dmemREN, dmemWEN,
           halt, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  stall, flush_if, flush_id, flush_ex, ihit, dhit,
           dmemREN_mem, dmemWEN_mem, halt_mem,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_clr, idex_clr, exmem_clr, dmemREN, dmemWEN,
           halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline latch enable/clear control with sticky halt and perf counters
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input logic        CLK,
  input logic        RST,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DDONE = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic memop;
  logic mem_ok;
  logic adv;
  logic anyflush;
  logic stall_eff;

  // State and counter registers; reset returns to RUN with cleared counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Advance decision, latch controls, gated dcache requests and next state
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    memop     = bus.dmemREN_mem | bus.dmemWEN_mem;
    // A data access already finished while fetch was stalled counts as satisfied
    mem_ok    = ~memop | bus.dhit | (state_q == S_DDONE);
    // RST forces every control low while it is held, independent of state
    adv       = bus.ihit & mem_ok & (state_q != S_HALT) & ~RST;
    anyflush  = bus.flush_if | bus.flush_id | bus.flush_ex;
    // A flush squashes the stalled instruction, so the stall is moot
    stall_eff = bus.stall & ~anyflush;

    bus.pc_en     = adv & ~stall_eff;
    bus.ifid_en   = adv & ~stall_eff;
    bus.ifid_clr  = adv & bus.flush_if;
    bus.idex_en   = adv;
    bus.idex_clr  = adv & (bus.flush_id | stall_eff);
    bus.exmem_en  = adv;
    bus.exmem_clr = adv & bus.flush_ex;
    bus.memwb_en  = adv;
    // Requests drop once the access completed so the dcache never sees it twice
    bus.dmemREN   = bus.dmemREN_mem & (state_q == S_RUN) & ~RST;
    bus.dmemWEN   = bus.dmemWEN_mem & (state_q == S_RUN) & ~RST;
    bus.halt      = (state_q == S_HALT);
    bus.stall_cnt = stall_cnt_q;
    bus.flush_cnt = flush_cnt_q;

    case (state_q)
      S_RUN: begin
        if (adv & bus.halt_mem) begin
          state_d = S_HALT;
        end else if (memop & bus.dhit & ~bus.ihit) begin
          state_d = S_DDONE;
        end
      end
      S_DDONE: begin
        if (bus.ihit & bus.halt_mem) begin
          state_d = S_HALT;
        end else if (bus.ihit) begin
          state_d = S_RUN;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase

    if (state_q != S_HALT) begin
      if ((~adv | stall_eff) && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if ((adv & anyflush) && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with directed and random stimulus
module tb_pipe_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] en;   // pc, ifid, idex, exmem, memwb
    logic [2:0] clr;  // ifid, idex, exmem
    logic [1:0] req;  // ren, wen
    logic       halt;
    int         scnt;
    int         fcnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: core is either running, holding a finished data access, or halted
  bit m_halted;
  bit m_data_done;
  int m_scnt;
  int m_fcnt;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit st, input bit fi, input bit fd, input bit fe,
                     input bit ih, input bit dh, input bit ren, input bit wen, input bit hm);
    exp_t e;
    bit   wants_data, data_ready, moves, any_fl, bubble;
    @(posedge CLK);
    #1;
    RST             = rst;
    bus.stall       = st;
    bus.flush_if    = fi;
    bus.flush_id    = fd;
    bus.flush_ex    = fe;
    bus.ihit        = ih;
    bus.dhit        = dh;
    bus.dmemREN_mem = ren;
    bus.dmemWEN_mem = wen;
    bus.halt_mem    = hm;
    if (rst) begin
      m_halted    = 0;
      m_data_done = 0;
      m_scnt      = 0;
      m_fcnt      = 0;
      e.en = '0; e.clr = '0; e.req = '0; e.halt = 1'b0; e.scnt = 0; e.fcnt = 0;
    end else begin
      wants_data = ren | wen;
      data_ready = !wants_data || dh || m_data_done;
      moves      = ih && data_ready && !m_halted;
      any_fl     = fi | fd | fe;
      bubble     = st && !any_fl;
      e.en   = {moves && !bubble, moves && !bubble, moves, moves, moves};
      e.clr  = {moves && fi, moves && (fd || bubble), moves && fe};
      e.req  = {ren && !m_halted && !m_data_done, wen && !m_halted && !m_data_done};
      e.halt = m_halted;
      e.scnt = m_scnt;
      e.fcnt = m_fcnt;
      if (!m_halted) begin
        if (!moves || bubble) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
        if (moves && any_fl)  m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
        if (moves && hm) begin
          m_halted    = 1;
          m_data_done = 0;
        end else if (m_data_done) begin
          if (ih) m_data_done = 0;
        end else if (wants_data && dh && !ih) begin
          m_data_done = 1;
        end
      end
    end
    sb.push_back(e);
  endtask

  // Monitor: outputs are stable mid-cycle, compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("enables", int'({bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}), int'(e.en));
        chk("clears", int'({bus.ifid_clr, bus.idex_clr, bus.exmem_clr}), int'(e.clr));
        chk("dmem_req", int'({bus.dmemREN, bus.dmemWEN}), int'(e.req));
        chk("halt", int'(bus.halt), int'(e.halt));
        chk("stall_cnt", int'(bus.stall_cnt), e.scnt);
        chk("flush_cnt", int'(bus.flush_cnt), e.fcnt);
      end
    end
  end

  initial begin
    bit st, fi, fd, fe, ih, dh, ren, wen, hm, rs;
    bus.stall = 0; bus.flush_if = 0; bus.flush_id = 0; bus.flush_ex = 0;
    bus.ihit = 0; bus.dhit = 0; bus.dmemREN_mem = 0; bus.dmemWEN_mem = 0; bus.halt_mem = 0;

    // reset, then clean running
    cyc(1, 0,0,0,0, 0,0, 0,0, 0);
    cyc(1, 0,0,0,0, 1,0, 0,0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0,0,0,0, 1,0, 0,0, 0);
    // load-use stall, then stall overridden by flush
    cyc(0, 1,0,0,0, 1,0, 0,0, 0);
    cyc(0, 1,0,1,0, 1,0, 0,0, 0);
    cyc(0, 0,1,0,1, 1,0, 0,0, 0);
    // data completes while fetch outstanding
    cyc(0, 0,0,0,0, 0,1, 1,0, 0);
    cyc(0, 0,0,0,0, 0,0, 1,0, 0);
    cyc(0, 0,0,0,0, 0,1, 1,0, 0);
    cyc(0, 0,0,0,0, 1,0, 1,0, 0);
    cyc(0, 0,0,0,0, 1,0, 1,0, 0);
    cyc(0, 0,0,0,0, 1,1, 1,0, 0);
    // store waits on dcache, then both hits together
    for (int i = 0; i < 4; i++) cyc(0, 0,0,0,0, 1,0, 0,1, 0);
    cyc(0, 0,0,0,0, 1,1, 0,1, 0);
    // halt is sticky until reset
    cyc(0, 0,0,0,0, 1,0, 0,0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1,1,0,0, 1,1, 1,1, 0);
    cyc(1, 0,0,0,0, 1,0, 0,0, 0);
    // saturation of stall counter
    for (int i = 0; i < 18; i++) cyc(0, 0,0,0,0, 0,0, 0,0, 0);
    @(negedge CLK);
    chk("stall_sat", int'(bus.stall_cnt), CMAX);
    cyc(1, 0,0,0,0, 0,0, 0,0, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rs  = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 3) == 0);
      fi  = ($urandom_range(0, 7) == 0);
      fd  = ($urandom_range(0, 7) == 0);
      fe  = ($urandom_range(0, 7) == 0);
      ih  = ($urandom_range(0, 3) != 0);
      dh  = ($urandom_range(0, 1) == 0);
      ren = ($urandom_range(0, 3) == 0);
      wen = !ren && ($urandom_range(0, 3) == 0);
      hm  = ($urandom_range(0, 39) == 0);
      cyc(rs, st, fi, fd, fe, ih, dh, ren, wen, hm);
    end

    @(negedge CLK);
    @(negedge CLK);
    chk("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
